// File: rtl/logic_op_scheduler_pkg.sv
// logic_op_scheduler_pkg: op codes (OR/AND/NOT/NAND) and FSM state codes shared by scheduler and logic unit
package logic_op_scheduler_pkg;
  localparam logic [1:0] OP_OR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;
endpackage

// File: rtl/logic_op_scheduler_logic_unit.sv
// logic_op_scheduler_logic_unit: NAND-only bitwise OR/AND/NOT(a)/NAND unit; in op[1:0], a, b; out y
module logic_op_scheduler_logic_unit import logic_op_scheduler_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] nab, na, nb, and_y, or_y;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand u_nab (nab[i], a[i], b[i]);
    nand u_na (na[i], a[i], a[i]);
    nand u_nb (nb[i], b[i], b[i]);
    nand u_and (and_y[i], nab[i], nab[i]);
    nand u_or (or_y[i], na[i], nb[i]);
  end
  assign y = op == OP_OR ? or_y : op == OP_AND ? and_y : op == OP_NOT ? na : nab;
endmodule

// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler: round-robin arbiter sharing one logic unit; req_valid/ready/op/a/b in, tagged registered rsp_valid/ready/id/data out, busy
module logic_op_scheduler import logic_op_scheduler_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);
  logic [1:0] state, op_q;
  logic [IDW-1:0] rr_ptr, gnt, id_q;
  logic [WIDTH-1:0] a_q, b_q, lu_y;
  logic any_valid;
  always_comb begin
    gnt = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt = IDW'((int'(rr_ptr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end
  assign req_ready = (reset_n && state == S_IDLE && any_valid) ? NREQ'(1) << gnt : '0;
  assign busy = state != S_IDLE;
  logic_op_scheduler_logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (lu_y)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      op_q <= OP_OR;
      a_q <= '0;
      b_q <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else if (state == S_IDLE) begin
      if (any_valid) begin
        op_q <= req_op[2*int'(gnt) +: 2];
        a_q <= req_a[WIDTH*int'(gnt) +: WIDTH];
        b_q <= req_b[WIDTH*int'(gnt) +: WIDTH];
        id_q <= gnt;
        rr_ptr <= IDW'((int'(gnt) + 1) % NREQ);
        state <= S_EXEC;
      end
    end else if (state == S_EXEC) begin
      rsp_data <= lu_y;
      rsp_id <= id_q;
      rsp_valid <= 1'b1;
      state <= S_RESP;
    end else if (state != S_RESP || rsp_ready) begin
      rsp_valid <= 1'b0;
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_logic_op_scheduler.sv
// tb_logic_op_scheduler: directed self-checking bench for logic_op_scheduler
module tb_logic_op_scheduler;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [7:0] req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic busy;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  logic_op_scheduler #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic setq(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask
  task automatic txn(input string tag, input logic [3:0] v, input logic [1:0] id, input logic [7:0] d);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << id;
    req_valid = v;
    #1;
    chk({tag, ".ready"}, {28'b0, req_ready}, {28'b0, one_hot});
    @(posedge clock); #1;
    chk({tag, ".exec"}, {26'b0, busy, rsp_valid, req_ready}, 32'h20);
    @(posedge clock); #1;
    chk({tag, ".valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".id"}, {30'b0, rsp_id}, {30'b0, id});
    chk({tag, ".data"}, {24'b0, rsp_data}, {24'b0, d});
    @(posedge clock); #1;
    chk({tag, ".idle"}, {30'b0, busy, rsp_valid}, 32'd0);
  endtask
  initial begin
    #3;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, busy}, 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clock); #1;
    setq(0, 2'b00, 8'hF0, 8'h3C);
    txn("op_or", 4'b0001, 2'd0, 8'hFC);
    setq(0, 2'b01, 8'hF0, 8'h3C);
    txn("op_and", 4'b0001, 2'd0, 8'h30);
    setq(0, 2'b10, 8'hF0, 8'h3C);
    txn("op_not", 4'b0001, 2'd0, 8'h0F);
    setq(0, 2'b11, 8'hF0, 8'h3C);
    txn("op_nand", 4'b0001, 2'd0, 8'hCF);
    rsp_ready = 1'b0;
    setq(1, 2'b00, 8'h20, 8'h01);
    req_valid = 4'b0011;
    #1;
    chk("rst.ready", {28'b0, req_ready}, 32'h2);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst.resp", {rsp_valid, rsp_id, rsp_data}, {21'b0, 1'b1, 2'd1, 8'h21});
    #2 reset_n = 1'b0;
    #1;
    chk("rst.async", {req_ready, rsp_valid, busy, rsp_id, rsp_data}, 32'd0);
    req_valid = '0;
    #2 reset_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("rst.idle", {30'b0, busy, rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) setq(i, 2'b00, 8'h10 << i, 8'(i));
    txn("rr0", 4'b1111, 2'd0, 8'h10);
    txn("rr1", 4'b1111, 2'd1, 8'h21);
    txn("rr2", 4'b1111, 2'd2, 8'h42);
    txn("rr3", 4'b1111, 2'd3, 8'h83);
    txn("rr4", 4'b1111, 2'd0, 8'h10);
    txn("wrap_pre", 4'b0100, 2'd2, 8'h42);
    txn("wrap_a", 4'b0101, 2'd0, 8'h10);
    txn("wrap_b", 4'b0101, 2'd2, 8'h42);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("bp.ready", {28'b0, req_ready}, 32'h2);
    @(posedge clock); #1;
    req_valid = 4'b1111;
    @(posedge clock); #1;
    for (int c = 0; c < 10; c++) begin
      chk("bp.hold", {rsp_valid, rsp_id, rsp_data, req_ready, busy}, {16'b0, 1'b1, 2'd1, 8'h21, 4'b0, 1'b1});
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp.release", {30'b0, busy, rsp_valid}, 32'd0);
    txn("bp_next", 4'b1111, 2'd2, 8'h42);
    setq(3, 2'b01, 8'hFF, 8'h0F);
    req_valid = 4'b1000;
    #1;
    chk("iso.ready", {28'b0, req_ready}, 32'h8);
    @(posedge clock); #1;
    req_valid = 4'b0000;
    setq(3, 2'b00, 8'h00, 8'hF0);
    @(posedge clock); #1;
    chk("iso.resp", {rsp_valid, rsp_id, rsp_data}, {21'b0, 1'b1, 2'd3, 8'h0F});
    @(posedge clock); #1;
    chk("iso.idle", {30'b0, busy, rsp_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
